// File: rtl/sender_rsa_pkg.sv
// Shared definitions for the oblivious-transfer RSA stages: state encodings and modular helpers.
package sender_rsa_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned IDX_W  = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXP0 = 2'd1,
    EXP1 = 2'd2,
    DONE = 2'd3
  } ot_state_e;

  typedef enum logic {
    RL_IDLE = 1'b0,
    RL_MUL  = 1'b1
  } rl_state_e;

  // (a - b) mod n for a, b < n, using a 33-bit intermediate
  function automatic logic [DATA_W-1:0] mod_sub(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic [DATA_W-1:0] n);
    logic [DATA_W:0] r;
    if (a >= b) r = {1'b0, a} - {1'b0, b};
    else        r = {1'b0, a} + {1'b0, n} - {1'b0, b};
    return r[DATA_W-1:0];
  endfunction

  // (a + b) mod n for a, b < n: 33-bit sum with one conditional subtract
  function automatic logic [DATA_W-1:0] mod_add(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic [DATA_W-1:0] n);
    logic [DATA_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, n}) s = s - {1'b0, n};
    return s[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/sender_rsa_rl_binary.sv
// Right-to-left binary modular exponentiation; each exponent bit runs one bit-serial
// interleaved multiply pass that forms result*base and base*base together.
module sender_rsa_rl_binary
  import sender_rsa_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [DATA_W-1:0] base,
  input  logic [DATA_W-1:0] exp,
  input  logic [DATA_W-1:0] N,
  output logic [DATA_W-1:0] result,
  output logic              md_end
);

  rl_state_e         state, state_n;
  logic [DATA_W-1:0] base_q, exp_q, n_q, res_q, acc_r, acc_b;
  logic [DATA_W-1:0] nxt_r, nxt_b, res_init;
  logic [IDX_W-1:0]  bit_idx;
  logic              mbit, last_bit, last_exp;

  assign mbit     = base_q[bit_idx];
  assign nxt_r    = mod_add(mod_add(acc_r, acc_r, n_q), mbit ? res_q : '0, n_q);
  assign nxt_b    = mod_add(mod_add(acc_b, acc_b, n_q), mbit ? base_q : '0, n_q);
  assign last_bit = (bit_idx == '0);
  assign last_exp = (exp_q[DATA_W-1:1] == '0);
  assign res_init = (N == DATA_W'(1)) ? '0 : DATA_W'(1);

  always_ff @(posedge clk) begin
    if (!rstn) state <= RL_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      RL_IDLE: if (start && exp != '0) state_n = RL_MUL;
      RL_MUL:  if (last_bit && last_exp) state_n = RL_IDLE;
      default: state_n = RL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      base_q  <= '0;
      exp_q   <= '0;
      n_q     <= '0;
      res_q   <= '0;
      acc_r   <= '0;
      acc_b   <= '0;
      bit_idx <= '0;
      result  <= '0;
      md_end  <= 1'b0;
    end else begin
      md_end <= 1'b0;
      case (state)
        RL_IDLE: begin
          if (start) begin
            base_q  <= base;
            exp_q   <= exp;
            n_q     <= N;
            res_q   <= res_init;
            acc_r   <= '0;
            acc_b   <= '0;
            bit_idx <= IDX_W'(DATA_W - 1);
            if (exp == '0) begin
              result <= res_init;
              md_end <= 1'b1;
            end
          end
        end
        RL_MUL: begin
          if (last_bit) begin
            if (exp_q[0]) res_q <= nxt_r;
            base_q  <= nxt_b;
            exp_q   <= exp_q >> 1;
            acc_r   <= '0;
            acc_b   <= '0;
            bit_idx <= IDX_W'(DATA_W - 1);
            if (last_exp) begin
              result <= exp_q[0] ? nxt_r : res_q;
              md_end <= 1'b1;
            end
          end else begin
            acc_r   <= nxt_r;
            acc_b   <= nxt_b;
            bit_idx <= bit_idx - IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sender_rsa.sv
// Sender RSA stage of 1-out-of-2 OT: k_i = ((v - x_i) mod N)^d, enc_i = (m_i + k_i) mod N.
module sender_rsa
  import sender_rsa_pkg::*;
#(
  parameter int unsigned W = DATA_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         gen,
  input  logic [W-1:0] v,
  input  logic [W-1:0] rand0,
  input  logic [W-1:0] rand1,
  input  logic [W-1:0] N,
  input  logic [W-1:0] priv_key,
  input  logic [W-1:0] msg0,
  input  logic [W-1:0] msg1,
  output logic [W-1:0] enc0,
  output logic [W-1:0] enc1,
  output logic         gen_end
);

  ot_state_e    state, state_n;
  logic [W-1:0] v_q, x1_q, n_q, d_q, m0_q, m1_q;
  logic [W-1:0] rl_base, rl_result;
  logic         rl_start, md_end;

  sender_rsa_rl_binary u_rl (
    .clk    (clk),
    .rstn   (~rst),
    .start  (rl_start),
    .base   (rl_base),
    .exp    (d_q),
    .N      (n_q),
    .result (rl_result),
    .md_end (md_end)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (gen) state_n = EXP0;
      EXP0:    if (md_end) state_n = EXP1;
      EXP1:    if (md_end) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Operand latches, engine handshake and masked outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q      <= '0;
      x1_q     <= '0;
      n_q      <= '0;
      d_q      <= '0;
      m0_q     <= '0;
      m1_q     <= '0;
      rl_base  <= '0;
      rl_start <= 1'b0;
      enc0     <= '0;
      enc1     <= '0;
      gen_end  <= 1'b0;
    end else begin
      rl_start <= 1'b0;
      gen_end  <= 1'b0;
      case (state)
        IDLE: begin
          if (gen) begin
            v_q      <= v;
            x1_q     <= rand1;
            n_q      <= N;
            d_q      <= priv_key;
            m0_q     <= msg0;
            m1_q     <= msg1;
            rl_base  <= mod_sub(v, rand0, N);
            rl_start <= 1'b1;
          end
        end
        EXP0: begin
          if (md_end) begin
            enc0     <= mod_add(m0_q, rl_result, n_q);
            rl_base  <= mod_sub(v_q, x1_q, n_q);
            rl_start <= 1'b1;
          end
        end
        EXP1: begin
          if (md_end) begin
            enc1    <= mod_add(m1_q, rl_result, n_q);
            gen_end <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
